mul_div_32: RTL and testbench

- Iterative multiply/divide unit that sits beside alu_32 in the execute stage.
- Takes the same two register-file operands (op1 = rs, op2 = rt) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI/LO registers, which the writeback mux reads for MFHI/MFLO.
- The control unit stalls the PC while busy is high.

---
 rtl/mul_div_32_pkg.sv | 34 +++
 rtl/md_sign_cond.sv | 15 +
 rtl/mul_div_32.sv | 209 ++++++++++++++++++++
 tb/tb_mul_div_32.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mul_div_32_pkg.sv
// Shared definitions for the mul_div_32 multiply/divide unit:
// operation encodings, FSM state encoding, iteration count and the
// per-operation context latched at the start edge.
package mul_div_32_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = $clog2(ITER + 1);

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Operation context captured at the start edge and consumed in FIX.
    typedef struct packed {
        logic is_div;
        logic neg_q;     // product / quotient sign
        logic neg_r;     // remainder sign
        logic zero_div;  // divisor was zero
    } md_ctx_t;

endpackage

// File: rtl/md_sign_cond.sv
// Conditional two's-complement negate.
// Ports: a   - input value
//        neg - when 1, output is -a (modulo 2^W); otherwise a
//        y_c - combinational result
module md_sign_cond #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y_c
);

    assign y_c = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mul_div_32.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO registers.
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring) over ITER
// cycles on operand magnitudes, then sign-corrects in one FIX cycle.
// MTHI/MTLO write op1 directly into HI/LO when idle.
// Ports: clk, rst_n      - clock, async active-low reset
//        op1, op2        - rs / rt operands, sampled on the start edge
//        md_op, start    - operation and request qualifier
//        busy            - iterative operation in flight
//        done            - one-cycle pulse when HI/LO take a mult/div result
//        div_by_zero     - divisor was zero; valid with done
//        hi, lo          - architectural HI/LO registers
module mul_div_32
    import mul_div_32_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       md_op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;  // product high word or remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;  // multiplier/product low or quotient
    logic [WIDTH-1:0]   op1_q, op1_d;        // raw op1 for the zero-divisor result
    md_ctx_t            ctx_q, ctx_d;
    logic               busy_d, done_d, dbz_d;
    logic [WIDTH-1:0]   hi_d, lo_d;

    // Request decode
    logic req_mul, req_div, req_signed, req_mthi, req_mtlo;

    always_comb begin
        req_mul    = 1'b0;
        req_div    = 1'b0;
        req_signed = 1'b0;
        req_mthi   = 1'b0;
        req_mtlo   = 1'b0;
        case (md_op_e'(md_op))
            MD_MULT:  begin req_mul = 1'b1; req_signed = 1'b1; end
            MD_MULTU: req_mul = 1'b1;
            MD_DIV:   begin req_div = 1'b1; req_signed = 1'b1; end
            MD_DIVU:  req_div = 1'b1;
            MD_MTHI:  req_mthi = 1'b1;
            MD_MTLO:  req_mtlo = 1'b1;
            default:  ;
        endcase
    end

    // Operand magnitudes
    logic [WIDTH-1:0] op1_abs_c, op2_abs_c;

    md_sign_cond #(.W(WIDTH)) u_abs1 (
        .a   (op1),
        .neg (req_signed & op1[WIDTH-1]),
        .y_c (op1_abs_c)
    );

    md_sign_cond #(.W(WIDTH)) u_abs2 (
        .a   (op2),
        .neg (req_signed & op2[WIDTH-1]),
        .y_c (op2_abs_c)
    );

    // One iteration step for each operation
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_borrow;
    logic [WIDTH-1:0] div_diff;

    assign mul_sum    = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, mcand_q})
                                    : {1'b0, acc_hi_q};
    assign div_shift  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_borrow = div_shift < {1'b0, mcand_q};
    // When there is no borrow the true difference is below the divisor, so
    // the low word alone is exact.
    assign div_diff   = div_shift[WIDTH-1:0] - mcand_q;

    // Result sign correction
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quo_c, rem_c;

    md_sign_cond #(.W(2 * WIDTH)) u_fix_prod (
        .a   ({acc_hi_q, acc_lo_q}),
        .neg (ctx_q.neg_q),
        .y_c (prod_c)
    );

    md_sign_cond #(.W(WIDTH)) u_fix_quo (
        .a   (acc_lo_q),
        .neg (ctx_q.neg_q),
        .y_c (quo_c)
    );

    md_sign_cond #(.W(WIDTH)) u_fix_rem (
        .a   (acc_hi_q),
        .neg (ctx_q.neg_r),
        .y_c (rem_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        op1_d    = op1_q;
        ctx_d    = ctx_q;
        busy_d   = busy;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        hi_d     = hi;
        lo_d     = lo;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_mthi) hi_d = op1;
                    if (req_mtlo) lo_d = op1;
                    if (req_mul || req_div) begin
                        mcand_d         = req_div ? op2_abs_c : op1_abs_c;
                        acc_lo_d        = req_div ? op1_abs_c : op2_abs_c;
                        acc_hi_d        = '0;
                        op1_d           = op1;
                        ctx_d.is_div    = req_div;
                        ctx_d.neg_q     = req_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
                        ctx_d.neg_r     = req_signed & op1[WIDTH-1];
                        ctx_d.zero_div  = req_div & (op2 == '0);
                        cnt_d           = CNT_W'(ITER);
                        busy_d          = 1'b1;
                        state_d         = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (ctx_q.is_div) begin
                    acc_hi_d = div_borrow ? div_shift[WIDTH-1:0] : div_diff;
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_borrow};
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end

            S_FIX: begin
                if (ctx_q.is_div) begin
                    if (ctx_q.zero_div) begin
                        lo_d  = '1;
                        hi_d  = op1_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = quo_c;
                        hi_d = rem_c;
                    end
                end else begin
                    {hi_d, lo_d} = prod_c;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            op1_q       <= '0;
            ctx_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            op1_q       <= op1_d;
            ctx_q       <= ctx_d;
            busy        <= busy_d;
            done        <= done_d;
            div_by_zero <= dbz_d;
            hi          <= hi_d;
            lo          <= lo_d;
        end
    end

endmodule

// File: tb/tb_mul_div_32.sv
// Directed testbench for mul_div_32: arithmetic results, latency, busy/done
// timing, zero divisor, MTHI/MTLO, ignored requests while busy, async reset.
module tb_mul_div_32;
    import mul_div_32_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  md_op;
    logic        start;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mul_div_32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op1         (op1),
        .op2         (op2),
        .md_op       (md_op),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a request at the current (post-edge) point, then wait for done
    // with a bound. edges counts clock edges after the start edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output logic busy_ok);
        md_op = op; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        edges = 0; busy_ok = 1'b1;
        while (done !== 1'b1 && edges < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; md_op = MD_NONE; op1 = '0; op2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_multu();
        int e; logic bok;
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, e, bok);
        checks++; if (e !== 33) begin errors++; $display("FAIL multu_latency: got %0d expected 33", e); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL multu_busy_run: got %b expected 1", bok); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_done: got %b expected 0", busy); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_mult();
        int e; logic bok;
        run_op(MD_MULT, 32'hFFFFFFFD, 32'd5, e, bok);
        checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_neg: got %h expected ffffffff_fffffff1", {hi, lo}); end
        @(posedge clk); #1;
        run_op(MD_MULT, 32'h80000000, 32'h80000000, e, bok);
        checks++; if ({hi, lo} !== 64'h40000000_00000000) begin errors++; $display("FAIL mult_minmin: got %h expected 40000000_00000000", {hi, lo}); end
        checks++; if (e !== 33) begin errors++; $display("FAIL mult_latency: got %0d expected 33", e); end
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        int e; logic bok;
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, e, bok);
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_q: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_r: got %h expected ffffffff", hi); end
        @(posedge clk); #1;
        run_op(MD_DIVU, 32'd7, 32'd2, e, bok);
        checks++; if ({hi, lo} !== {32'd1, 32'd3}) begin errors++; $display("FAIL divu_7_2: got %h expected 00000001_00000003", {hi, lo}); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divu_dbz: got %b expected 0", div_by_zero); end
        @(posedge clk); #1;
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, e, bok);
        checks++; if ({hi, lo} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_overflow: got %h expected 00000000_80000000", {hi, lo}); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int e; logic bok;
        run_op(MD_DIV, 32'h00001234, 32'd0, e, bok);
        checks++; if (e !== 33) begin errors++; $display("FAIL dbz_latency: got %0d expected 33", e); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL dbz_lo: got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL dbz_hi: got %h expected 00001234", hi); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
        @(posedge clk); #1;
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %b expected 0", div_by_zero); end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; md_op = MD_MTHI; op1 = 32'hDEADBEEF;
        @(posedge clk); #1;
        checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi: got %h expected deadbeef", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags: got busy=%b done=%b expected 0 0", busy, done); end
        md_op = MD_MTLO; op1 = 32'h12345678;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        checks++; if ({hi, lo} !== 64'hDEADBEEF_12345678) begin errors++; $display("FAIL mtlo: got %h expected deadbeef_12345678", {hi, lo}); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_flags: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_busy_ignore();
        int e;
        md_op = MD_MULTU; op1 = 32'd3; op2 = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        e = 0;
        // Hammer MTLO/MTHI and scramble operands while the multiply runs
        for (int i = 0; i < 6; i++) begin
            md_op = (i % 2 == 0) ? MD_MTLO : MD_MTHI;
            op1 = 32'h55555555; op2 = 32'hAAAAAAAA; start = 1'b1;
            @(posedge clk); #1;
            e++;
        end
        start = 1'b0; md_op = MD_NONE;
        while (done !== 1'b1 && e < 40) begin
            @(posedge clk); #1;
            e++;
        end
        checks++; if (e !== 33) begin errors++; $display("FAIL busy_ign_latency: got %0d expected 33", e); end
        checks++; if ({hi, lo} !== 64'h00000000_0000000C) begin errors++; $display("FAIL busy_ign_result: got %h expected 00000000_0000000c", {hi, lo}); end
    endtask

    task automatic test_back_to_back();
        int e; logic bok;
        // Issued in the done cycle of the previous operation
        run_op(MD_MULTU, 32'd6, 32'd7, e, bok);
        checks++; if (e !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", e); end
        checks++; if ({hi, lo} !== 64'h00000000_0000002A) begin errors++; $display("FAIL b2b_result: got %h expected 00000000_0000002a", {hi, lo}); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int e; logic bok;
        start = 1'b1; md_op = MD_MTHI; op1 = 32'h0F0F0F0F;
        @(posedge clk); #1;
        md_op = MD_MTLO; op1 = 32'hF0F0F0F0;
        @(posedge clk); #1;
        md_op = MD_MULTU; op1 = 32'd3; op2 = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE;
        repeat (9) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo: got %h expected 0", {hi, lo}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(MD_DIVU, 32'd100, 32'd7, e, bok);
        checks++; if (e !== 33) begin errors++; $display("FAIL abort_divu_latency: got %0d expected 33", e); end
        checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL abort_divu_result: got %h expected 00000002_0000000e", {hi, lo}); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
